// File: rtl/seq_fixed_divider.sv
// seq_fixed_divider
//   Iterative signed fixed-point divider computing Q = (A << IN_SHIFT) / B.
//   It is a restoring divider that produces one quotient bit per clock and
//   truncates toward zero. Operands enter through a valid/ready handshake.
//   The result is held until the output handshake completes.
//
// Optional feature macro: SATURATE_EN
//   Defined   : adds port ovf, and Q clamps to the signed BITS range.
//   Undefined : Q is the low BITS bits of the signed quotient (wrap-around).
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair A/B valid
//   in_ready   divider idle, can accept operands
//   A, B       signed dividend / divisor (BITS wide)
//   out_valid  Q/div_zero valid and held
//   out_ready  consumer accepts result
//   Q          signed quotient (BITS wide)
//   div_zero   result came from B == 0
//   ovf        (SATURATE_EN only) quotient was clamped
module seq_fixed_divider #(
    parameter int BITS     = 8,
    parameter int IN_SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] Q,
`ifdef SATURATE_EN
    output logic            ovf,
`endif
    output logic            div_zero
);

    localparam int N  = BITS + IN_SHIFT;
    localparam int CW = $clog2(N);

    localparam logic [BITS-1:0] MAX_Q = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] MIN_Q = {1'b1, {(BITS-1){1'b0}}};

`ifdef SATURATE_EN
    // Largest quotient magnitudes that still fit for each sign.
    localparam logic [N-1:0] POS_LIM = {{(IN_SHIFT+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic [N-1:0] NEG_LIM = POS_LIM + N'(1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic [N:0]      dvd_q;
    logic [BITS:0]   bmag_q;
    logic [BITS:0]   rem_q;
    logic [N-1:0]    quot_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [BITS-1:0] q_q;
    logic            div_zero_q;
    logic            ovf_q;

    // Operand conditioning
    logic [BITS:0]   a_ext;
    logic [BITS:0]   b_ext;
    logic [BITS:0]   amag;
    logic [BITS:0]   bmag;
    logic [N:0]      dvd_init;

    // One restoring step
    logic [BITS:0]   rem_shift;
    logic            rem_ge;
    logic [BITS:0]   rem_d;
    logic [N-1:0]    quot_d;
    logic [N:0]      dvd_d;

    // Signed result formatting
    logic [BITS-1:0] mag_lo;
    logic [BITS-1:0] res_q;
    logic            res_ovf;

    always_comb begin
        a_ext    = {A[BITS-1], A};
        b_ext    = {B[BITS-1], B};
        amag     = A[BITS-1] ? -a_ext : a_ext;
        bmag     = B[BITS-1] ? -b_ext : b_ext;
        dvd_init = (N+1)'(amag) << IN_SHIFT;
    end

    // Whole-vector shifts are used so every stored bit is consumed.
    // The bits shifted out are always zero because the remainder stays below
    // |B| and the top dividend bit never holds data.
    always_comb begin
        rem_shift = (rem_q << 1) | {{BITS{1'b0}}, dvd_q[N-1]};
        rem_ge    = (rem_shift >= bmag_q);
        rem_d     = rem_ge ? (rem_shift - bmag_q) : rem_shift;
        quot_d    = (quot_q << 1) | {{(N-1){1'b0}}, rem_ge};
        dvd_d     = dvd_q << 1;
    end

    // The low BITS bits of the negated magnitude equal the wrapped signed quotient.
    always_comb begin
        mag_lo  = quot_d[BITS-1:0];
        res_q   = neg_q ? -mag_lo : mag_lo;
        res_ovf = 1'b0;
`ifdef SATURATE_EN
        if (neg_q && (quot_d > NEG_LIM)) begin
            res_q   = MIN_Q;
            res_ovf = 1'b1;
        end else if (!neg_q && (quot_d > POS_LIM)) begin
            res_q   = MAX_Q;
            res_ovf = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dvd_q       <= '0;
            bmag_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q      <= A[BITS-1] ^ B[BITS-1];
                        dvd_q      <= dvd_init;
                        bmag_q     <= bmag;
                        rem_q      <= '0;
                        quot_q     <= '0;
                        in_ready_q <= 1'b0;
                        if (B == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            div_zero_q  <= 1'b1;
                            ovf_q       <= 1'b0;
                            q_q         <= A[BITS-1] ? MIN_Q : MAX_Q;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CW'(N-1);
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    dvd_q  <= dvd_d;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        q_q         <= res_q;
                        ovf_q       <= res_ovf;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        div_zero_q  <= 1'b0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign div_zero  = div_zero_q;
`ifdef SATURATE_EN
    assign ovf       = ovf_q;
`else
    // ovf_q is reset and cleared but has no port in this build.
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_fixed_divider.sv
// Self-checking bench for seq_fixed_divider.
// Instance u0 uses IN_SHIFT=0 and instance u1 uses IN_SHIFT=4; both have BITS=8.
module tb_seq_fixed_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv[2], ir[2], ovl[2], ordy[2], dz[2];
    logic [7:0] a[2], b[2], q[2];
`ifdef SATURATE_EN
    logic       of[2];
`endif

    seq_fixed_divider #(.BITS(8), .IN_SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .A(a[0]), .B(b[0]), .out_valid(ovl[0]), .out_ready(ordy[0]),
        .Q(q[0]),
`ifdef SATURATE_EN
        .ovf(of[0]),
`endif
        .div_zero(dz[0])
    );

    seq_fixed_divider #(.BITS(8), .IN_SHIFT(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .A(a[1]), .B(b[1]), .out_valid(ovl[1]), .out_ready(ordy[1]),
        .Q(q[1]),
`ifdef SATURATE_EN
        .ovf(of[1]),
`endif
        .div_zero(dz[1])
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic       dz;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input logic [7:0] qv, input logic dzv, input logic ovv, input int lat);
        exp_t e;
        e.q = qv; e.dz = dzv; e.ov = ovv; e.lat = lat;
        return e;
    endfunction

    // Reference model built on integer arithmetic (truncating division).
    function automatic exp_t model(input int sh, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int sa, sbv, quo;
        sa  = $signed(av);
        sbv = $signed(bv);
        e.ov = 1'b0;
        if (bv == 8'd0) begin
            e.dz  = 1'b1;
            e.q   = av[7] ? 8'h80 : 8'h7f;
            e.lat = 1;
        end else begin
            e.dz  = 1'b0;
            quo   = (sa * (1 << sh)) / sbv;
            e.lat = 8 + sh + 1;
            e.q   = quo[7:0];
`ifdef SATURATE_EN
            if (quo > 127) begin
                e.q = 8'h7f; e.ov = 1'b1;
            end else if (quo < -128) begin
                e.q = 8'h80; e.ov = 1'b1;
            end
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one transaction on instance s. During the hold cycles out_ready is
    // kept low, and in_valid pulses that must be ignored are driven.
    task automatic op(input int s, input logic [7:0] av, input logic [7:0] bv,
                      input exp_t e, input int hold);
        int   n;
        exp_t g;
        sb.push_back(e);
        n = 0;
        while (!ir[s] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_accept", ir[s], 1);
        a[s] = av; b[s] = bv; iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        n = 1;
        while (!ovl[s] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        g = sb.pop_front();
        chk("out_valid", ovl[s], 1);
        chk("latency", n, g.lat);
        chk("Q", q[s], g.q);
        chk("div_zero", dz[s], g.dz);
`ifdef SATURATE_EN
        chk("ovf", of[s], g.ov);
`endif
        chk("in_ready_busy", ir[s], 0);
        for (int h = 0; h < hold; h++) begin
            a[s] = ~av; b[s] = 8'd3; iv[s] = 1'b1;
            @(posedge clk); #1;
            iv[s] = 1'b0;
            chk("hold_out_valid", ovl[s], 1);
            chk("hold_Q", q[s], g.q);
            chk("hold_div_zero", dz[s], g.dz);
            chk("hold_in_ready", ir[s], 0);
        end
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
        chk("post_out_valid", ovl[s], 0);
        chk("post_in_ready", ir[s], 1);
        chk("post_div_zero", dz[s], 0);
        chk("post_Q_kept", q[s], g.q);
`ifdef SATURATE_EN
        chk("post_ovf", of[s], 0);
`endif
    endtask

    initial begin
        exp_t       e;
        logic [7:0] ra, rb;
        int         s;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_in_ready", ir[i], 1);
            chk("reset_out_valid", ovl[i], 0);
            chk("reset_Q", q[i], 0);
            chk("reset_div_zero", dz[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic signed division with IN_SHIFT=0
        op(0, 8'd100, 8'd7, mk(8'd14, 1'b0, 1'b0, 9), 0);
        op(0, -8'sd100, 8'd7, mk(8'hf2, 1'b0, 1'b0, 9), 0);
        op(0, -8'sd100, -8'sd7, mk(8'd14, 1'b0, 1'b0, 9), 0);

        // Fixed-point with IN_SHIFT=4
        op(1, 8'd16, 8'd32, mk(8'd8, 1'b0, 1'b0, 13), 0);
        op(1, 8'd48, 8'd16, mk(8'd48, 1'b0, 1'b0, 13), 0);

        // Divide by zero
        op(0, 8'd5, 8'd0, mk(8'h7f, 1'b1, 1'b0, 1), 0);
        op(0, -8'sd5, 8'd0, mk(8'h80, 1'b1, 1'b0, 1), 0);

        // Overflow: -128 / -1
`ifdef SATURATE_EN
        op(0, 8'h80, 8'hff, mk(8'h7f, 1'b0, 1'b1, 9), 0);
`else
        op(0, 8'h80, 8'hff, mk(8'h80, 1'b0, 1'b0, 9), 0);
`endif

        // Backpressure, then an immediate follow-up pair
        op(0, 8'd100, 8'd7, mk(8'd14, 1'b0, 1'b0, 9), 5);
        op(0, 8'd9, 8'd2, mk(8'd4, 1'b0, 1'b0, 9), 0);

        // Asynchronous reset mid-calculation
        a[0] = 8'd100; b[0] = 8'd7; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_before_reset", ir[0], 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", ir[0], 1);
        chk("abort_out_valid", ovl[0], 0);
        chk("abort_Q", q[0], 0);
        chk("abort_div_zero", dz[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        op(0, 8'd50, 8'd5, mk(8'd10, 1'b0, 1'b0, 9), 0);

        // Random pairs on both instances against the integer model
        for (int i = 0; i < 12; i++) begin
            s  = i % 2;
            ra = 8'($urandom_range(0, 255));
            rb = (i == 5) ? 8'd0 : 8'($urandom_range(0, 255));
            e  = model(s * 4, ra, rb);
            op(s, ra, rb, e, i % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
